// File: rtl/button_conditioner_if.sv
// Bus bundle for button_conditioner: raw button levels and toggle clear in,
// debounced levels, press strobes and toggle bits out.
interface button_conditioner_if #(
    parameter int N_BTN = 5
);
    logic [N_BTN-1:0] btn_raw;
    logic             clr_toggle;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] pulse;
    logic [N_BTN-1:0] toggle;

    modport master (
        output btn_raw, clr_toggle,
        input  level, pulse, toggle
    );

    modport slave (
        input  btn_raw, clr_toggle,
        output level, pulse, toggle
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel synchronize, debounce, press strobe and toggle for N_BTN buttons.
// Auto-repeat is compiled in only when BUTTON_AUTO_REPEAT_EN is defined.
module button_conditioner #(
    parameter int          N_BTN           = 5,
    parameter int          DEBOUNCE_CYCLES = 16,
    parameter int unsigned TOGGLE_MASK     = 5'b00010,
    parameter int unsigned REPEAT_MASK     = 5'b11101,
    parameter int          REPEAT_DELAY    = 5000,
    parameter int          REPEAT_PERIOD   = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);
    localparam int               CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]    DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_BTN-1:0] TGL_M   = TOGGLE_MASK[N_BTN-1:0];

    // Masks wider than the channel count would silently drop bits.
    if (N_BTN < 1 || N_BTN > 16 || DEBOUNCE_CYCLES < 1 ||
        REPEAT_PERIOD < 2 || REPEAT_DELAY < REPEAT_PERIOD ||
        TOGGLE_MASK >= (32'd1 << N_BTN) || REPEAT_MASK >= (32'd1 << N_BTN)) begin : g_bad_params
        $error("button_conditioner: illegal parameter combination");
    end

    logic [N_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_BTN-1:0] level_q, level_d, level_dly_q, level_dly_d;
    logic [N_BTN-1:0] pulse_q, pulse_d, toggle_q, toggle_d;
    logic [N_BTN-1:0] press;
    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];

    always_comb begin
        sync1_d     = bus.btn_raw;
        sync2_d     = sync1_q;
        level_dly_d = level_q;
        level_d     = level_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // Initial press strobe lands one edge after the debounced level rises.
        press    = level_q & ~level_dly_q;
        toggle_d = bus.clr_toggle ? '0 : (toggle_q ^ (press & TGL_M));
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int               RW       = $clog2(REPEAT_DELAY);
    localparam logic [RW-1:0]    DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]    PER_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [N_BTN-1:0] REP_M    = REPEAT_MASK[N_BTN-1:0];

    typedef enum logic [1:0] {R_IDLE, R_DELAY, R_REPEAT} rep_state_e;

    rep_state_e       state_q [N_BTN];
    rep_state_e       state_d [N_BTN];
    logic [RW-1:0]    rcnt_q  [N_BTN];
    logic [RW-1:0]    rcnt_d  [N_BTN];
    logic [N_BTN-1:0] rep, fall;

    always_comb begin
        fall = level_q & ~level_d;
        rep  = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = rcnt_q[i];
            // A falling level wins over any repeat due on the same edge.
            if (!REP_M[i] || fall[i]) begin
                state_d[i] = R_IDLE;
                rcnt_d[i]  = '0;
            end else begin
                case (state_q[i])
                    R_IDLE: begin
                        if (press[i]) begin
                            state_d[i] = R_DELAY;
                            rcnt_d[i]  = DLY_LAST;
                        end
                    end
                    R_DELAY, R_REPEAT: begin
                        if (rcnt_q[i] == '0) begin
                            rep[i]     = 1'b1;
                            state_d[i] = R_REPEAT;
                            rcnt_d[i]  = PER_LAST;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] - 1'b1;
                        end
                    end
                    default: begin
                        state_d[i] = R_IDLE;
                        rcnt_d[i]  = '0;
                    end
                endcase
            end
        end
        pulse_d = press | rep;
    end
`else
    always_comb begin
        pulse_d = press;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            pulse_q     <= '0;
            toggle_q    <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
`ifdef BUTTON_AUTO_REPEAT_EN
                state_q[i] <= R_IDLE;
                rcnt_q[i]  <= '0;
`endif
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            pulse_q     <= pulse_d;
            toggle_q    <= toggle_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
`ifdef BUTTON_AUTO_REPEAT_EN
                state_q[i] <= state_d[i];
                rcnt_q[i]  <= rcnt_d[i];
`endif
            end
        end
    end

    assign bus.level  = level_q;
    assign bus.pulse  = pulse_q;
    assign bus.toggle = toggle_q;
endmodule
